// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 host transmitter: byte request in,
// busy/done/error status out.
interface ps2_host_tx_if;
    logic       iSend;
    logic [7:0] iData;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    modport master (output iSend, iData, input oBusy, oDone, oError);
    modport slave  (input iSend, iData, output oBusy, oDone, oError);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data bits plus
// odd parity on device clock falling edges, release for stop, check device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         Clock,
    input  logic         Reset,
    ps2_host_tx_if.slave bus,
    input  logic         iPs2Clk,
    input  logic         iPs2Data,
    output logic         oPs2ClkDrive,
    output logic         oPs2DataDrive
);
    localparam logic [15:0] INHIBIT_LAST = 16'(INHIBIT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SHIFT, STOP, ACK, WAIT_IDLE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_data_sync;
    logic        r_clk_prev;
    logic [7:0]  r_byte;
    logic        r_parity;
    logic [3:0]  r_bit_idx;
    logic [15:0] r_cnt;
    logic        r_ack_bit;
    logic        r_clk_drive;
    logic        r_data_drive;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_fall;
    logic        w_timeout;
    logic [15:0] w_cnt_inc;

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_timeout = (r_cnt == TIMEOUT_LAST);
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    assign oPs2ClkDrive  = r_clk_drive;
    assign oPs2DataDrive = r_data_drive;
    assign bus.oBusy     = r_busy;
    assign bus.oDone     = r_done;
    assign bus.oError    = r_error;

    // NOTE: all state here is sequential, so every assignment is non-blocking; the
    // synchronizer stages only work as a chain because each reads the old value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_clk_sync   <= 2'b00;
            r_data_sync  <= 2'b00;
            r_clk_prev   <= 1'b0;
            r_byte       <= 8'h00;
            r_parity     <= 1'b0;
            r_bit_idx    <= 4'd0;
            r_cnt        <= 16'd0;
            r_ack_bit    <= 1'b0;
            r_clk_drive  <= 1'b0;
            r_data_drive <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], iPs2Clk};
            r_data_sync <= {r_data_sync[0], iPs2Data};
            r_clk_prev  <= r_clk_sync[1];
            r_done      <= 1'b0;
            r_error     <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_clk_drive  <= 1'b0;
                    r_data_drive <= 1'b0;
                    r_busy       <= 1'b0;
                    if (bus.iSend) begin
                        r_byte      <= bus.iData;
                        r_parity    <= ~^bus.iData;
                        r_cnt       <= 16'd0;
                        r_bit_idx   <= 4'd0;
                        r_clk_drive <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (r_cnt == INHIBIT_LAST) begin
                        r_clk_drive  <= 1'b0;
                        r_data_drive <= 1'b1;
                        r_cnt        <= 16'd0;
                        r_state      <= RTS;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    // Every device-clocked state shares the edge-to-edge watchdog.
                    r_cnt <= w_fall ? 16'd0 : w_cnt_inc;
                    if (!w_fall && w_timeout) begin
                        r_clk_drive  <= 1'b0;
                        r_data_drive <= 1'b0;
                        r_busy       <= 1'b0;
                        r_error      <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        case (r_state)
                            RTS: begin
                                if (w_fall) begin
                                    r_data_drive <= ~r_byte[0];
                                    r_bit_idx    <= 4'd0;
                                    r_state      <= SHIFT;
                                end
                            end
                            SHIFT: begin
                                if (w_fall) begin
                                    if (r_bit_idx == 4'd8) begin
                                        r_data_drive <= 1'b0;
                                        r_state      <= STOP;
                                    end else if (r_bit_idx == 4'd7) begin
                                        r_data_drive <= ~r_parity;
                                        r_bit_idx    <= 4'd8;
                                    end else begin
                                        r_data_drive <= ~r_byte[r_bit_idx[2:0] + 3'd1];
                                        r_bit_idx    <= r_bit_idx + 4'd1;
                                    end
                                end
                            end
                            STOP: begin
                                if (w_fall) begin
                                    r_ack_bit <= r_data_sync[1];
                                    r_state   <= ACK;
                                end
                            end
                            ACK: begin
                                if (r_ack_bit) begin
                                    r_busy  <= 1'b0;
                                    r_error <= 1'b1;
                                    r_state <= IDLE;
                                end else begin
                                    r_state <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (r_clk_sync[1] && r_data_sync[1]) begin
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_state <= IDLE;
                                end
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
